pc_unit: RTL and testbench

Program-counter and fetch-sequencing stage that sits directly upstream of the instruction memory. It drives the fetch address into the synchronous instruction RAM and tracks which PC the RAM's output currently belongs to. It computes redirect targets for branch, jump and jump-register, and marks squashed wrong-path fetches so decode ignores them. No branch delay slots: every taken redirect costs exactly one bubble.

---
 rtl/pc_unit.sv | 103 ++++++++++
 tb/tb_pc_unit.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// Program counter / fetch sequencer feeding a synchronous instruction RAM.
// Optional PC_ALIGN_CHECK_EN: misaligned jr traps to EXC_VECTOR with epc/addr_err.
module pc_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0380
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch,
    input  logic [15:0] imm16,
    input  logic        jump,
    input  logic [25:0] imm26,
    input  logic        jr,
    input  logic [31:0] jr_target,
    output logic [31:0] pc,
    output logic [31:0] pc_d,
    output logic [31:0] pc_d_plus4,
    output logic        inst_valid,
    output logic        addr_err,
    output logic [31:0] epc
);

    localparam logic [1:0] ST_BOOT   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_SQUASH = 2'd2;

    logic [1:0]  state;
    logic        redirect;
    logic        misaligned;
    logic [31:0] target;

    function automatic logic [31:0] branch_target(input logic [31:0] base,
                                                  input logic [15:0] off);
        logic signed [31:0] off_s;
        off_s = {{14{off[15]}}, off, 2'b00};
        return base + $unsigned(off_s);
    endfunction

    assign pc_d_plus4 = pc_d + 32'd4;

    // Only a live decode instruction may redirect; boot and squashed slots never do.
    assign redirect = inst_valid && !stall && (state == ST_RUN) && (branch || jump || jr);

    always_comb begin
        target     = branch_target(pc_d_plus4, imm16);
        misaligned = 1'b0;
        if (jr) begin
`ifdef PC_ALIGN_CHECK_EN
            if (jr_target[1:0] != 2'b00) begin
                target     = EXC_VECTOR;
                misaligned = 1'b1;
            end else begin
                target = jr_target;
            end
`else
            target = {jr_target[31:2], 2'b00};
`endif
        end else if (jump) begin
            target = {pc_d_plus4[31:28], imm26, 2'b00};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc         <= RESET_PC;
            pc_d       <= RESET_PC;
            inst_valid <= 1'b0;
            state      <= ST_BOOT;
        end else if (!stall) begin
            pc_d <= pc;
            if (redirect) begin
                pc         <= target;
                inst_valid <= 1'b0;
                state      <= ST_SQUASH;
            end else begin
                pc         <= pc + 32'd4;
                inst_valid <= 1'b1;
                state      <= ST_RUN;
            end
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_err <= 1'b0;
            epc      <= 32'h0;
        end else begin
            addr_err <= redirect && jr && misaligned;
            if (redirect && jr && misaligned)
                epc <= pc_d;
        end
    end
`else
    assign addr_err = 1'b0;
    assign epc      = 32'h0;

    logic unused_align;
    assign unused_align = ^{jr_target[1:0], EXC_VECTOR, misaligned};
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Directed, table-driven bench for pc_unit; expectations follow PC_ALIGN_CHECK_EN if defined.
module tb_pc_unit;

`ifdef PC_ALIGN_CHECK_EN
    localparam bit M = 1'b1;
`else
    localparam bit M = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, branch, jump, jr;
    logic [15:0] imm16;
    logic [25:0] imm26;
    logic [31:0] jr_target;
    logic [31:0] pc, pc_d, pc_d_plus4, epc;
    logic        inst_valid, addr_err;

    int errors = 0;
    int checks = 0;

    pc_unit dut (
        .clk(clk), .rst(rst), .stall(stall), .branch(branch), .imm16(imm16),
        .jump(jump), .imm26(imm26), .jr(jr), .jr_target(jr_target),
        .pc(pc), .pc_d(pc_d), .pc_d_plus4(pc_d_plus4), .inst_valid(inst_valid),
        .addr_err(addr_err), .epc(epc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall, br, jmp, jr;
        logic [15:0] imm16;
        logic [25:0] imm26;
        logic [31:0] jrt;
        logic [31:0] e_pc, e_pcd, e_epc;
        logic        e_v, e_err;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic s, input logic b, input logic [15:0] i16,
                       input logic j, input logic [25:0] i26, input logic r,
                       input logic [31:0] rt, input logic [31:0] epc_x,
                       input logic [31:0] epcd_x, input logic ev,
                       input logic eerr, input logic [31:0] eepc);
        vec_t v;
        v.stall = s; v.br = b; v.imm16 = i16; v.jmp = j; v.imm26 = i26; v.jr = r;
        v.jrt = rt; v.e_pc = epc_x; v.e_pcd = epcd_x; v.e_v = ev; v.e_err = eerr;
        v.e_epc = eepc;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        stall = v.stall; branch = v.br; imm16 = v.imm16; jump = v.jmp;
        imm26 = v.imm26; jr = v.jr; jr_target = v.jrt;
    endtask

    task automatic idle();
        stall = 0; branch = 0; imm16 = 0; jump = 0; imm26 = 0; jr = 0; jr_target = 0;
    endtask

    logic [31:0] ep;

    initial begin
        ep = M ? 32'h404 : 32'h0;
        // free run from reset: pc_d 0..0x20
        for (int k = 1; k <= 9; k++)
            add(0,0,0,0,0,0,0, 32'(4*k), 32'(4*(k-1)), 1, 0, 0);
        // branch back by 2 words from pc_d=0x20; branch during squash ignored
        add(0,1,16'hFFFE,0,0,0,0, 32'h1C, 32'h24, 0, 0, 0);
        add(0,1,16'hFFFE,0,0,0,0, 32'h20, 32'h1C, 1, 0, 0);
        add(0,0,0,0,0,0,0,        32'h24, 32'h20, 1, 0, 0);
        // stall with jr pending: frozen, then jr taken
        for (int k = 0; k < 3; k++)
            add(1,0,0,0,0,1,32'h400, 32'h24, 32'h20, 1, 0, 0);
        add(0,0,0,0,0,1,32'h400,  32'h400, 32'h24, 0, 0, 0);
        add(0,0,0,0,0,0,0,        32'h404, 32'h400, 1, 0, 0);
        add(0,0,0,0,0,0,0,        32'h408, 32'h404, 1, 0, 0);
        // misaligned jr
        add(0,0,0,0,0,1,32'h402,  M ? 32'h380 : 32'h400, 32'h408, 0, M, ep);
        add(0,0,0,0,0,0,0,        M ? 32'h384 : 32'h404, M ? 32'h380 : 32'h400, 1, 0, ep);
        // all three set: jr wins
        add(0,1,16'h0040,1,26'h0000040,1,32'h800, 32'h800, M ? 32'h384 : 32'h404, 0, 0, ep);
        add(0,0,0,0,0,0,0,        32'h804, 32'h800, 1, 0, ep);
        // jump beats branch
        add(0,0,0,0,0,1,32'h1000_0010, 32'h1000_0010, 32'h804, 0, 0, ep);
        add(0,0,0,0,0,0,0,        32'h1000_0014, 32'h1000_0010, 1, 0, ep);
        add(0,1,16'h0010,1,26'h0000040,0,0, 32'h1000_0100, 32'h1000_0014, 0, 0, ep);
        add(0,0,0,0,0,0,0,        32'h1000_0104, 32'h1000_0100, 1, 0, ep);
        // sequential wrap
        add(0,0,0,0,0,1,32'hFFFF_FFF8, 32'hFFFF_FFF8, 32'h1000_0104, 0, 0, ep);
        add(0,0,0,0,0,0,0,        32'hFFFF_FFFC, 32'hFFFF_FFF8, 1, 0, ep);
        add(0,0,0,0,0,0,0,        32'h0, 32'hFFFF_FFFC, 1, 0, ep);
        add(0,0,0,0,0,0,0,        32'h4, 32'h0, 1, 0, ep);
        // forward branch from pc_d=0
        add(0,1,16'h0003,0,0,0,0, 32'h10, 32'h4, 0, 0, ep);
        add(0,0,0,0,0,0,0,        32'h14, 32'h10, 1, 0, ep);

        idle();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_pc", pc, 32'h0);
        chk("rst_pc_d", pc_d, 32'h0);
        chk("rst_valid", {31'b0, inst_valid}, 32'h0);
        chk("rst_addr_err", {31'b0, addr_err}, 32'h0);
        chk("rst_epc", epc, 32'h0);
        rst = 1'b0;

        // stall during boot holds everything
        stall = 1;
        @(posedge clk); @(negedge clk);
        chk("boot_stall_pc", pc, 32'h0);
        chk("boot_stall_valid", {31'b0, inst_valid}, 32'h0);
        stall = 0;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            @(posedge clk); @(negedge clk);
            chk($sformatf("v%0d_pc", i), pc, vecs[i].e_pc);
            chk($sformatf("v%0d_pc_d", i), pc_d, vecs[i].e_pcd);
            chk($sformatf("v%0d_plus4", i), pc_d_plus4, vecs[i].e_pcd + 32'd4);
            chk($sformatf("v%0d_valid", i), {31'b0, inst_valid}, {31'b0, vecs[i].e_v});
            chk($sformatf("v%0d_addr_err", i), {31'b0, addr_err}, {31'b0, vecs[i].e_err});
            chk($sformatf("v%0d_epc", i), epc, vecs[i].e_epc);
        end

        // async reset during the squash cycle
        idle();
        jr = 1; jr_target = 32'h100;
        @(posedge clk); @(negedge clk);
        idle();
        chk("sq_pc", pc, 32'h100);
        chk("sq_valid", {31'b0, inst_valid}, 32'h0);
        #1 rst = 1'b1;
        #1;
        chk("sq_rst_pc", pc, 32'h0);
        chk("sq_rst_pc_d", pc_d, 32'h0);
        chk("sq_rst_valid", {31'b0, inst_valid}, 32'h0);
        chk("sq_rst_epc", epc, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("post_rst_pc", pc, 32'h4);
        chk("post_rst_pc_d", pc_d, 32'h0);
        chk("post_rst_valid", {31'b0, inst_valid}, 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
